// File: rtl/sigmoid_pkg.sv
// Shared constants, chord table and helpers for the piecewise-linear sigmoid/tanh unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sigmoid_pkg;

   // Internal fixed-point precision: Q.12, 1.0 == 4096.
   localparam int IF_W     = 12;
   localparam int SEG_BITS = 3;
   localparam int NSEG     = 1 << SEG_BITS;

   // Chord end-points round(sigmoid(k) * 4096) for k = 0..8.
   localparam logic [IF_W:0] PWL_T [0:NSEG] = '{
      13'd2048, 13'd2994, 13'd3608, 13'd3902, 13'd4022,
      13'd4069, 13'd4086, 13'd4092, 13'd4095
   };

   typedef enum logic {
      ACT_SIGMOID = 1'b0,
      ACT_TANH    = 1'b1
   } act_mode_e;

   // Magnitude of a w-bit two's complement value (already sign-extended to
   // 32 bits). The most negative value has no positive twin, so it clamps to
   // the largest positive w-bit value instead of wrapping.
   function automatic logic [31:0] sat_abs(input logic signed [31:0] v, input int w);
      logic signed [31:0] vmin;
      vmin = -(32'sd1 <<< (w - 1));
      if (v == vmin)
         sat_abs = 32'h7FFF_FFFF >> (32 - w);
      else if (v < 0)
         sat_abs = 32'(-v);
      else
         sat_abs = 32'(v);
   endfunction

endpackage

// File: rtl/sigmoid_pwl_stage_ctl.sv
// One-entry valid/ready register slice control; the owner holds the data regs and loads them on 'load'.
// Latency: 1 clock from up transfer to dn_valid.
// Backpressure: up_ready = empty or draining this cycle, so bubbles collapse and full rate is sustained.
//
// Ports: clk, rst_n (async active-low); up_valid/up_ready upstream handshake;
//        dn_valid/dn_ready downstream handshake; load = enable for this stage's data registers.
module sigmoid_pwl_stage_ctl (
   input  logic clk,
   input  logic rst_n,
   input  logic up_valid,
   output logic up_ready,
   output logic dn_valid,
   input  logic dn_ready,
   output logic load
);

   logic valid_q;

   assign up_ready = !valid_q || dn_ready;
   assign load     = up_valid && up_ready;
   assign dn_valid = valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         valid_q <= 1'b0;
      else if (load)
         valid_q <= 1'b1;
      else if (dn_ready)
         valid_q <= 1'b0;
   end

endmodule

// File: rtl/sigmoid_pwl_pipe.sv
// Pipelined sigmoid / tanh (tanh(x) = 2*sigmoid(2x)-1) via an 8-segment chord table on |x| in [0,8).
// Latency: 3 clocks (S1 fold/scale, S2 chord interpolate, S3 unfold/round), one sample per clock.
// Backpressure: ready ripples back combinationally; with out_ready low exactly 3 samples are held.
//
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_x/in_mode input stream
//        (in_mode 0 = sigmoid, 1 = tanh); out_valid/out_ready/out_y output stream;
//        busy = any stage holds a sample.
module sigmoid_pwl_pipe
   import sigmoid_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_x,
   input  logic              in_mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_y,
   output logic              busy
);

   localparam int SH = IF_W - FRAC_W;       // input up-shift / output down-shift
   localparam int AW = DATA_W + SH + 2;     // room for scaling, tanh doubling and the 8.0 limit

   localparam logic [AW-1:0] SAT_LIM = AW'(NSEG) << IF_W;

   if (FRAC_W < 4 || FRAC_W > IF_W) begin : g_bad_frac
      $error("sigmoid_pwl_pipe: FRAC_W must be in 4..12");
   end
   if (DATA_W < FRAC_W + 2 || DATA_W > 32) begin : g_bad_data
      $error("sigmoid_pwl_pipe: DATA_W must be in FRAC_W+2..32");
   end

   // ---------------- stage control ----------------
   logic s1_valid, s1_load, s2_rdy;
   logic s2_valid, s2_load, s3_rdy;
   logic s3_load;

   sigmoid_pwl_stage_ctl u_ctl1 (
      .clk(clk), .rst_n(rst_n),
      .up_valid(in_valid), .up_ready(in_ready),
      .dn_valid(s1_valid), .dn_ready(s2_rdy), .load(s1_load)
   );
   sigmoid_pwl_stage_ctl u_ctl2 (
      .clk(clk), .rst_n(rst_n),
      .up_valid(s1_valid), .up_ready(s2_rdy),
      .dn_valid(s2_valid), .dn_ready(s3_rdy), .load(s2_load)
   );
   sigmoid_pwl_stage_ctl u_ctl3 (
      .clk(clk), .rst_n(rst_n),
      .up_valid(s2_valid), .up_ready(s3_rdy),
      .dn_valid(out_valid), .dn_ready(out_ready), .load(s3_load)
   );

   assign busy = s1_valid || s2_valid || out_valid;

   // ---------------- S1: fold to |x|, scale to Q.12, segment select ----------------
   logic [31:0]         mag32;
   logic [AW-1:0]       a_mag, a_act;
   logic                sat_c;

   always_comb begin
      mag32 = sat_abs(32'(signed'(in_x)), DATA_W);
      a_mag = AW'(mag32) << SH;
      // AW leaves headroom, so doubling cannot wrap; anything past 8.0 saturates anyway.
      a_act = (act_mode_e'(in_mode) == ACT_TANH) ? (a_mag << 1) : a_mag;
      sat_c = (a_act >= SAT_LIM);
   end

   logic                s1_sign, s1_mode, s1_sat;
   logic [SEG_BITS-1:0] s1_idx;
   logic [IF_W-1:0]     s1_frac;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_sign <= 1'b0;
         s1_mode <= 1'b0;
         s1_sat  <= 1'b0;
         s1_idx  <= '0;
         s1_frac <= '0;
      end else if (s1_load) begin
         s1_sign <= in_x[DATA_W-1];
         s1_mode <= in_mode;
         s1_sat  <= sat_c;
         s1_idx  <= a_act[IF_W+SEG_BITS-1:IF_W];
         s1_frac <= a_act[IF_W-1:0];
      end
   end

   // ---------------- S2: chord interpolation on the positive half ----------------
   logic [SEG_BITS:0] idx_lo, idx_hi;
   logic [IF_W:0]     t_lo, t_hi, slope, ypos_c;
   logic [2*IF_W:0]   prod;

   always_comb begin
      idx_lo = {1'b0, s1_idx};
      idx_hi = idx_lo + (SEG_BITS+1)'(1);
      t_lo   = PWL_T[idx_lo];
      t_hi   = PWL_T[idx_hi];
      slope  = t_hi - t_lo;                  // table is monotonic, never negative
      prod   = (2*IF_W+1)'(slope) * (2*IF_W+1)'(s1_frac);
      ypos_c = s1_sat ? PWL_T[NSEG] : (t_lo + (IF_W+1)'(prod >> IF_W));
   end

   logic          s2_sign, s2_mode;
   logic [IF_W:0] s2_ypos;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_sign <= 1'b0;
         s2_mode <= 1'b0;
         s2_ypos <= '0;
      end else if (s2_load) begin
         s2_sign <= s1_sign;
         s2_mode <= s1_mode;
         s2_ypos <= ypos_c;
      end
   end

   // ---------------- S3: unfold sign, tanh remap, round to output format ----------------
   localparam logic signed [IF_W+2:0] ONE_Q = 15'sd1 <<< IF_W;

   logic signed [IF_W+2:0] ypos_s, y_full;
   logic [DATA_W-1:0]      y_out_c;

   always_comb begin
      ypos_s = signed'({2'b00, s2_ypos});
      if (act_mode_e'(s2_mode) == ACT_TANH)
         y_full = s2_sign ? (ONE_Q - (ypos_s <<< 1)) : ((ypos_s <<< 1) - ONE_Q);
      else
         y_full = s2_sign ? (ONE_Q - ypos_s) : ypos_s;
   end

   if (SH == 0) begin : g_no_round
      assign y_out_c = DATA_W'(y_full);
   end else begin : g_round
      localparam logic signed [IF_W+3:0] RND = 16'sd1 <<< (SH - 1);
      logic signed [IF_W+3:0] y_sum, y_sh;
      always_comb begin
         y_sum   = (IF_W+4)'(y_full) + RND;
         y_sh    = y_sum >>> SH;             // floor after +half: round half up
         y_out_c = DATA_W'(y_sh);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         out_y <= '0;
      else if (s3_load)
         out_y <= y_out_c;
   end

endmodule
